// File: rtl/video_chunk_scheduler.sv
// Issues {row, chunk} read requests for one video frame while keeping the
// number of issued-but-unconsumed chunks under a credit limit.
module video_chunk_scheduler #(
    parameter int CHUNK_BITS      = 5,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             scalerClock,
    input  logic                             reset,
    input  logic                             frameStart,
    input  logic [11-CHUNK_BITS-1:0]         frameWidthChunks,
    input  logic [10:0]                      frameHeight,
    output logic                             requestFifoWriteEnable,
    input  logic                             requestFifoFull,
    output logic [11+(11-CHUNK_BITS)-1:0]    requestFifoWriteData,
    input  logic                             pixelAccepted,
    output logic                             busy,
    output logic                             frameDone,
    output logic [2:0]                       outstandingChunks,
    output logic                             underflowError
);

    localparam int HACTIVE_BITS  = 11;
    localparam int VACTIVE_BITS  = 11;
    localparam int CHUNKNUM_BITS = HACTIVE_BITS - CHUNK_BITS;
    localparam int REQUEST_BITS  = VACTIVE_BITS + CHUNKNUM_BITS;

    localparam logic [2:0] IDLE  = 3'b001;
    localparam logic [2:0] ISSUE = 3'b010;
    localparam logic [2:0] DRAIN = 3'b100;

    logic [2:0]               state;
    logic [CHUNKNUM_BITS-1:0] chunk;
    logic [CHUNKNUM_BITS-1:0] lastChunk;
    logic [VACTIVE_BITS-1:0]  row;
    logic [VACTIVE_BITS-1:0]  lastRow;
    logic [CHUNK_BITS-1:0]    retireCount;
    logic                     pixelValid;
    logic                     retire;
    logic                     zeroFrame;
    logic                     drainDone;

    assign zeroFrame = (frameWidthChunks == '0) || (frameHeight == '0);
    assign requestFifoWriteEnable = (state == ISSUE) && !requestFifoFull
                                    && (outstandingChunks < 3'(MAX_OUTSTANDING));
    assign requestFifoWriteData = REQUEST_BITS'({row, chunk});
    assign busy       = (state != IDLE);
    assign pixelValid = pixelAccepted && (outstandingChunks != 3'd0);
    assign retire     = pixelValid && (retireCount == '1);
    assign drainDone  = (state == DRAIN) && (outstandingChunks == 3'd0);

    // Frame sequencing: walk chunks across each row, rows down the frame,
    // then wait for every issued chunk to be consumed before finishing.
    always_ff @(posedge scalerClock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            row       <= '0;
            chunk     <= '0;
            lastRow   <= '0;
            lastChunk <= '0;
            frameDone <= 1'b0;
        end else begin
            frameDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (frameStart) begin
                        if (zeroFrame) begin
                            frameDone <= 1'b1;
                        end else begin
                            lastChunk <= frameWidthChunks - CHUNKNUM_BITS'(1);
                            lastRow   <= frameHeight - VACTIVE_BITS'(1);
                            row       <= '0;
                            chunk     <= '0;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (requestFifoWriteEnable) begin
                        if (chunk == lastChunk) begin
                            chunk <= '0;
                            row   <= row + VACTIVE_BITS'(1);
                            if (row == lastRow) begin
                                state <= DRAIN;
                            end
                        end else begin
                            chunk <= chunk + CHUNKNUM_BITS'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drainDone) begin
                        state     <= IDLE;
                        frameDone <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Credit tracking: a chunk retires when its last pixel is consumed; a
    // write and a retire in the same cycle cancel out.
    always_ff @(posedge scalerClock or posedge reset) begin
        if (reset) begin
            retireCount       <= '0;
            outstandingChunks <= 3'd0;
            underflowError    <= 1'b0;
        end else begin
            if (drainDone) begin
                retireCount <= '0;
            end else if (pixelValid) begin
                retireCount <= retireCount + CHUNK_BITS'(1);
            end
            if (requestFifoWriteEnable && !retire) begin
                outstandingChunks <= outstandingChunks + 3'd1;
            end else if (retire && !requestFifoWriteEnable) begin
                outstandingChunks <= outstandingChunks - 3'd1;
            end
            if (pixelAccepted && (outstandingChunks == 3'd0)) begin
                underflowError <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_chunk_scheduler.sv
// Randomized bench for video_chunk_scheduler: a frame-level model predicts
// the request sequence, credit count and completion pulses every cycle.
module tb_video_chunk_scheduler;

    localparam int MAXO = 4;
    localparam int PIX  = 32;

    logic        scalerClock = 1'b0;
    logic        reset;
    logic        frameStart;
    logic [5:0]  frameWidthChunks;
    logic [10:0] frameHeight;
    logic        requestFifoWriteEnable;
    logic        requestFifoFull;
    logic [16:0] requestFifoWriteData;
    logic        pixelAccepted;
    logic        busy;
    logic        frameDone;
    logic [2:0]  outstandingChunks;
    logic        underflowError;

    int    vectors     = 0;
    int    miscompares = 0;
    int    writeCount  = 0;
    int    doneCount   = 0;
    string curTest     = "none";

    // Frame-level model: requests are numbered 0..w*h-1 in raster order, and
    // credits in use are writes minus fully consumed chunks.
    bit mActive, mDone, mUnderflow;
    int mW, mH, mTotal, mIssued, mWrites, mPix;

    video_chunk_scheduler dut (
        .scalerClock            (scalerClock),
        .reset                  (reset),
        .frameStart             (frameStart),
        .frameWidthChunks       (frameWidthChunks),
        .frameHeight            (frameHeight),
        .requestFifoWriteEnable (requestFifoWriteEnable),
        .requestFifoFull        (requestFifoFull),
        .requestFifoWriteData   (requestFifoWriteData),
        .pixelAccepted          (pixelAccepted),
        .busy                   (busy),
        .frameDone              (frameDone),
        .outstandingChunks      (outstandingChunks),
        .underflowError         (underflowError)
    );

    always #5 scalerClock = ~scalerClock;

    function automatic int modelOuts();
        return mWrites - mPix / PIX;
    endfunction

    task automatic modelReset();
        mActive = 0; mDone = 0; mUnderflow = 0;
        mW = 0; mH = 0; mTotal = 0; mIssued = 0; mWrites = 0; mPix = 0;
    endtask

    // One clock: compare outputs against the model, then advance the model
    // with the same inputs the DUT sees on the rising edge.
    task automatic tick();
        int          outs;
        bit          expWe;
        bit          dn;
        logic [16:0] expData;
        #1;
        outs  = modelOuts();
        expWe = mActive && (mIssued < mTotal) && !requestFifoFull && (outs < MAXO);
        vectors++;
        if (requestFifoWriteEnable !== expWe) begin
            miscompares++;
            $display("[TB] FAIL %s/writeEnable: got %0b expected %0b", curTest, requestFifoWriteEnable, expWe);
        end
        if (expWe) begin
            expData = {11'(mIssued / mW), 6'(mIssued % mW)};
            vectors++;
            if (requestFifoWriteData !== expData) begin
                miscompares++;
                $display("[TB] FAIL %s/writeData: got %0h expected %0h", curTest, requestFifoWriteData, expData);
            end
        end
        vectors++;
        if (busy !== mActive) begin
            miscompares++;
            $display("[TB] FAIL %s/busy: got %0b expected %0b", curTest, busy, mActive);
        end
        vectors++;
        if (frameDone !== mDone) begin
            miscompares++;
            $display("[TB] FAIL %s/frameDone: got %0b expected %0b", curTest, frameDone, mDone);
        end
        vectors++;
        if (outstandingChunks !== 3'(outs)) begin
            miscompares++;
            $display("[TB] FAIL %s/outstanding: got %0d expected %0d", curTest, outstandingChunks, outs);
        end
        vectors++;
        if (underflowError !== mUnderflow) begin
            miscompares++;
            $display("[TB] FAIL %s/underflow: got %0b expected %0b", curTest, underflowError, mUnderflow);
        end
        if (requestFifoWriteEnable === 1'b1) writeCount++;
        if (frameDone === 1'b1) doneCount++;
        @(posedge scalerClock);
        dn = 0;
        if (pixelAccepted && outs == 0) mUnderflow = 1;
        if (!mActive) begin
            if (frameStart) begin
                if (frameWidthChunks == 0 || frameHeight == 0) begin
                    dn = 1;
                end else begin
                    mActive = 1;
                    mW = int'(frameWidthChunks);
                    mH = int'(frameHeight);
                    mTotal = mW * mH;
                    mIssued = 0; mWrites = 0; mPix = 0;
                end
            end
        end else if (mIssued == mTotal && outs == 0) begin
            mActive = 0;
            dn = 1;
        end else begin
            if (expWe) begin
                mIssued++;
                mWrites++;
            end
            if (pixelAccepted && outs > 0) mPix++;
        end
        mDone = dn;
        @(negedge scalerClock);
    endtask

    task automatic startFrame(input int w, input int h);
        frameWidthChunks = 6'(w);
        frameHeight      = 11'(h);
        frameStart       = 1'b1;
        tick();
        frameStart       = 1'b0;
    endtask

    // Random back-pressure and consumer until the frame completes.
    task automatic drain(input int budget, input bit allowFull);
        int startDone = doneCount;
        bit got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            requestFifoFull = allowFull && ($urandom_range(0, 3) == 0);
            pixelAccepted   = (modelOuts() > 0) && ($urandom_range(0, 3) != 0);
            tick();
            if (doneCount != startDone) got = 1;
        end
        requestFifoFull = 1'b0;
        pixelAccepted   = 1'b0;
        vectors++;
        if (!got) begin
            miscompares++;
            $display("[TB] FAIL %s/timeout: got no frameDone expected frameDone within %0d cycles", curTest, budget);
        end
    endtask

    task automatic applyReset();
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (requestFifoWriteEnable !== 1'b0 || busy !== 1'b0 || frameDone !== 1'b0 ||
            outstandingChunks !== 3'd0 || underflowError !== 1'b0 || requestFifoWriteData !== 17'h0) begin
            miscompares++;
            $display("[TB] FAIL %s/inReset: got we=%b busy=%b done=%b outs=%0d uf=%b data=%0h expected all zero",
                     curTest, requestFifoWriteEnable, busy, frameDone, outstandingChunks, underflowError,
                     requestFifoWriteData);
        end
        @(posedge scalerClock);
        @(negedge scalerClock);
        reset = 1'b0;
        modelReset();
        tick();
    endtask

    task automatic test_reset();
        curTest = "reset";
        applyReset();
    endtask

    task automatic test_basic_frame();
        int w0, d0;
        curTest = "basic";
        w0 = writeCount; d0 = doneCount;
        startFrame(2, 2);
        drain(2000, 0);
        tick();
        vectors++;
        if (writeCount - w0 != 4 || doneCount - d0 != 1) begin
            miscompares++;
            $display("[TB] FAIL basic/counts: got writes=%0d dones=%0d expected writes=4 dones=1",
                     writeCount - w0, doneCount - d0);
        end
    endtask

    task automatic test_credit_limit();
        int w0;
        curTest = "credit";
        w0 = writeCount;
        startFrame(8, 1);
        for (int i = 0; i < 20; i++) tick();
        vectors++;
        if (writeCount - w0 != 4 || outstandingChunks !== 3'd4) begin
            miscompares++;
            $display("[TB] FAIL credit/limit: got writes=%0d outs=%0d expected writes=4 outs=4",
                     writeCount - w0, outstandingChunks);
        end
        pixelAccepted = 1'b1;
        for (int i = 0; i < PIX; i++) tick();
        pixelAccepted = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if (writeCount - w0 != 5) begin
            miscompares++;
            $display("[TB] FAIL credit/refill: got writes=%0d expected 5", writeCount - w0);
        end
        drain(3000, 1);
    endtask

    task automatic test_back_pressure();
        curTest = "backpressure";
        startFrame(6, 2);
        for (int i = 0; i < 20 && mIssued < 3; i++) tick();
        requestFifoFull = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (requestFifoWriteEnable !== 1'b0 || requestFifoWriteData !== 17'h3) begin
                miscompares++;
                $display("[TB] FAIL backpressure/hold: got we=%b data=%0h expected we=0 data=3",
                         requestFifoWriteEnable, requestFifoWriteData);
            end
        end
        requestFifoFull = 1'b0;
        tick();
        drain(3000, 1);
    endtask

    task automatic test_simultaneous();
        curTest = "simultaneous";
        startFrame(8, 1);
        for (int i = 0; i < 20 && modelOuts() < 3; i++) tick();
        requestFifoFull = 1'b1;
        pixelAccepted   = 1'b1;
        for (int i = 0; i < PIX - 1; i++) tick();
        requestFifoFull = 1'b0;
        tick();
        requestFifoFull = 1'b1;
        pixelAccepted   = 1'b0;
        tick();
        vectors++;
        if (outstandingChunks !== 3'd3) begin
            miscompares++;
            $display("[TB] FAIL simultaneous/outs: got %0d expected 3", outstandingChunks);
        end
        requestFifoFull = 1'b0;
        drain(3000, 1);
    endtask

    task automatic test_zero_size();
        int w0, d0;
        curTest = "zero";
        w0 = writeCount; d0 = doneCount;
        startFrame(4, 0);
        tick();
        startFrame(0, 3);
        tick();
        tick();
        vectors++;
        if (writeCount != w0 || doneCount - d0 != 2) begin
            miscompares++;
            $display("[TB] FAIL zero/pulses: got writes=%0d dones=%0d expected writes=0 dones=2",
                     writeCount - w0, doneCount - d0);
        end
        curTest = "restart";
        w0 = writeCount;
        startFrame(3, 1);
        startFrame(1, 1);
        drain(2000, 1);
        vectors++;
        if (writeCount - w0 != 3) begin
            miscompares++;
            $display("[TB] FAIL restart/ignored: got writes=%0d expected 3", writeCount - w0);
        end
    endtask

    task automatic test_reset_mid_issue();
        int d0;
        curTest = "midreset";
        startFrame(5, 2);
        for (int i = 0; i < 20 && mIssued < 3; i++) tick();
        d0 = doneCount;
        applyReset();
        tick();
        vectors++;
        if (doneCount != d0) begin
            miscompares++;
            $display("[TB] FAIL midreset/noDone: got %0d pulses expected 0", doneCount - d0);
        end
        startFrame(1, 1);
        drain(1000, 0);
        curTest = "stray";
        pixelAccepted = 1'b1;
        tick();
        pixelAccepted = 1'b0;
        tick();
        vectors++;
        if (underflowError !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stray/underflow: got %b expected 1", underflowError);
        end
    endtask

    task automatic test_random_frames();
        curTest = "random";
        for (int f = 0; f < 6; f++) begin
            startFrame($urandom_range(1, 5), $urandom_range(1, 3));
            drain(4000, 1);
            for (int i = 0; i < $urandom_range(0, 3); i++) tick();
        end
    endtask

    initial begin
        reset            = 1'b1;
        frameStart       = 1'b0;
        frameWidthChunks = 6'd0;
        frameHeight      = 11'd0;
        requestFifoFull  = 1'b0;
        pixelAccepted    = 1'b0;
        modelReset();
        @(negedge scalerClock);
        test_reset();
        test_basic_frame();
        test_credit_limit();
        test_back_pressure();
        test_simultaneous();
        test_zero_size();
        test_reset_mid_issue();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_chunk_scheduler.md
VIDEO_CHUNK_SCHEDULER -- requirements
Module: video_chunk_scheduler

Parameters
REQ-001 The block SHALL have parameter CHUNK_BITS, default 5, meaning log2 of pixels per chunk.
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of issued, unretired chunks (range 1..7).
REQ-003 The block SHALL fix HACTIVE_BITS=11, VACTIVE_BITS=11, CHUNKNUM_BITS=HACTIVE_BITS-CHUNK_BITS and REQUEST_BITS=VACTIVE_BITS+CHUNKNUM_BITS as localparams.

Interface
REQ-004 The block SHALL have reset: asynchronous, active-high. Its clock SHALL be scalerClock.
REQ-005 scalerClock  in  1  clock for all logic.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 frameStart  in  1  single-cycle pulse that starts a frame.
REQ-008 frameWidthChunks  in  CHUNKNUM_BITS  chunks per row; sampled on an accepted frameStart.
REQ-009 frameHeight  in  VACTIVE_BITS  rows per frame; sampled on an accepted frameStart.
REQ-010 requestFifoWriteEnable  out  1  writes one chunk request to the source request FIFO.
REQ-011 requestFifoFull  in  1  full flag of the request FIFO.
REQ-012 requestFifoWriteData  out  REQUEST_BITS  {row, chunkNum}.
REQ-013 pixelAccepted  in  1  one pulse per pixel the consumer takes from the response FIFO.
REQ-014 busy  out  1  high while the state is not IDLE.
REQ-015 frameDone  out  1  single-cycle pulse when a frame completes.
REQ-016 outstandingChunks  out  3  count of issued, unretired chunks.
REQ-017 underflowError  out  1  sticky flag; set when pixelAccepted arrives with outstandingChunks==0.

Function
REQ-018 The block SHALL implement a one-hot state machine with states IDLE, ISSUE and DRAIN.
REQ-019 IDLE: an accepted frameStart SHALL latch the width and height, clear row and chunk to 0, and transition to ISSUE.
REQ-020 IDLE: a frameStart with width==0 or height==0 SHALL be accepted, SHALL issue no requests, SHALL stay in IDLE, and SHALL pulse frameDone on the next cycle.
REQ-021 A frameStart received while busy SHALL be ignored.
REQ-022 requestFifoWriteEnable SHALL be combinational and equal to (state==ISSUE && !requestFifoFull && outstandingChunks<MAX_OUTSTANDING).
REQ-023 requestFifoWriteData SHALL be driven from the row and chunk registers and SHALL be valid whenever requestFifoWriteEnable is high.
REQ-024 On each write, chunk SHALL increment.
- When chunk == width-1: chunk SHALL clear to 0 and row SHALL increment.
- When additionally row == height-1: the state SHALL go to DRAIN.
REQ-025 When the write enable is low in ISSUE, row, chunk and state SHALL hold.
REQ-026 A retire counter of CHUNK_BITS width SHALL increment on each pixelAccepted that has outstandingChunks>0. On wrap from all-ones to 0, one chunk SHALL retire.
REQ-027 On the same cycle, outstandingChunks SHALL:
- increment on write-only;
- decrement on retire-only;
- remain unchanged on write and retire together.
REQ-028 A pixelAccepted with outstandingChunks==0 SHALL not change any counter and SHALL set underflowError.
REQ-029 DRAIN: when outstandingChunks==0, the block SHALL go to IDLE and pulse frameDone on the same edge. frameDone SHALL be registered and high for exactly one cycle.
REQ-030 busy SHALL deassert on the cycle frameDone is high.
REQ-031 The retire counter SHALL be 0 whenever the state enters IDLE.

Reset
REQ-032 Reset SHALL force all of the following, regardless of any frame in progress:
- state to IDLE;
- row, chunk, retire counter and outstandingChunks to 0;
- busy, frameDone and underflowError to 0.
REQ-033 requestFifoWriteEnable SHALL be 0 during reset and on the first cycle after reset.
REQ-034 Reset asserted mid-frame SHALL abandon the frame with no frameDone pulse.

Verification
REQ-035 Basic frame: width=2, height=2, FIFO never full, a 32-pixel consumer per chunk -> 4 writes with data {0,0},{0,1},{1,0},{1,1}; frameDone pulses once after the 128th pixelAccepted; busy then falls.
REQ-036 Credit limit: width=8, height=1, no pixelAccepted -> exactly 4 writes; outstandingChunks==4; then 32 pixelAccepted -> exactly one further write.
REQ-037 Back-pressure: requestFifoFull held for 10 cycles mid-row -> no writes and row/chunk unchanged; release -> issue resumes at the next chunk with no skip or duplicate.
REQ-038 Simultaneous events: at outstanding=3, a write and the 32nd pixel on the same cycle -> outstandingChunks stays 3.
REQ-039 Zero size and restart: a frameStart with height=0 -> frameDone pulses next cycle with no writes. A frameStart while busy is ignored.
REQ-040 Reset mid-ISSUE: all outputs return to their reset values, there is no frameDone, and a new frameStart restarts at {0,0}. A stray pixelAccepted in IDLE sets underflowError.
